stack_op_sequencer: RTL

- Initiator/controller side of the CPU's hardware stack: accepts one stack-machine operation at a time over a valid/ready request port.
- Drives the stack's push/pop/tos strobes and data-in, and captures the stack's registered data-out.
- Sequences multi-step ops (binary ALU, DUP, NOT) and tracks stack occupancy to flag underflow/overflow before touching the stack.
- Sits between the multi-cycle control unit and the stack block.

---
 rtl/stack_op_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/stack_op_sequencer.sv
// Stack operation sequencer: accepts one stack-machine op at a time, checks
// occupancy for underflow/overflow up front, then drives the stack's
// push/pop/tos strobes step by step and reports the result with a done pulse.
module stack_op_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_imm,
  output logic             stk_push,
  output logic             stk_pop,
  output logic             stk_tos,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  output logic             done,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       err,
  output logic [DEPTH:0]   depth
);

  localparam logic [2:0] OpPushi = 3'd0;
  localparam logic [2:0] OpPop   = 3'd1;
  localparam logic [2:0] OpTos   = 3'd2;
  localparam logic [2:0] OpAdd   = 3'd3;
  localparam logic [2:0] OpSub   = 3'd4;
  localparam logic [2:0] OpAnd   = 3'd5;
  localparam logic [2:0] OpNot   = 3'd6;
  localparam logic [2:0] OpDup   = 3'd7;

  localparam logic [1:0] ErrOk    = 2'b00;
  localparam logic [1:0] ErrUnder = 2'b01;
  localparam logic [1:0] ErrOver  = 2'b10;

  localparam logic [DEPTH:0] CapVal = {1'b1, {DEPTH{1'b0}}};

  typedef enum logic [2:0] {
    StIdle, StRdA, StCapA, StRdB, StCapB, StWr, StDone, StErrDone
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] imm_q, a_q, b_q, res_q, result;
  logic [1:0]       err_q, err_code;
  logic [DEPTH:0]   depth_q;
  logic             accept, need1, need2, underflow, overflow;

  assign accept = (state_q == StIdle) && req_valid;
  assign depth  = depth_q;

  // Occupancy checks on the incoming op, evaluated against the current depth
  always_comb begin
    need1     = (req_op == OpPop) || (req_op == OpTos) || (req_op == OpNot) || (req_op == OpDup);
    need2     = (req_op == OpAdd) || (req_op == OpSub) || (req_op == OpAnd);
    underflow = (need1 && (depth_q == '0)) || (need2 && (depth_q < (DEPTH+1)'(2)));
    overflow  = ((req_op == OpPushi) || (req_op == OpDup)) && (depth_q == CapVal);
    // Underflow wins: DUP on an empty stack is reported as underflow
    err_code  = underflow ? ErrUnder : (overflow ? ErrOver : ErrOk);
  end

  // Value pushed in WR, derived from the latched op and captured operands
  always_comb begin
    result = '0;
    unique case (op_q)
      OpPushi: result = imm_q;
      OpAdd:   result = b_q + a_q;
      OpSub:   result = b_q - a_q;
      OpAnd:   result = b_q & a_q;
      OpNot:   result = ~a_q;
      OpDup:   result = a_q;
      OpPop:   result = a_q;
      OpTos:   result = a_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing per op class
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (err_code != ErrOk)     state_d = StErrDone;
          else if (req_op == OpPushi) state_d = StWr;
          else                        state_d = StRdA;
        end
      end
      StRdA:  state_d = StCapA;
      StCapA: begin
        if ((op_q == OpPop) || (op_q == OpTos))      state_d = StDone;
        else if ((op_q == OpNot) || (op_q == OpDup)) state_d = StWr;
        else                                         state_d = StRdB;
      end
      StRdB:     state_d = StCapB;
      StCapB:    state_d = StWr;
      StWr:      state_d = StDone;
      StDone:    state_d = StIdle;
      StErrDone: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; strobes are mutually exclusive by construction
  always_comb begin
    req_ready = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_tos   = 1'b0;
    stk_din   = '0;
    done      = 1'b0;
    res_data  = '0;
    err       = ErrOk;
    unique case (state_q)
      StIdle: req_ready = 1'b1;
      StRdA: begin
        if ((op_q == OpTos) || (op_q == OpDup)) stk_tos = 1'b1;
        else                                    stk_pop = 1'b1;
      end
      StRdB: stk_pop = 1'b1;
      StWr: begin
        stk_push = 1'b1;
        stk_din  = result;
      end
      StDone: begin
        done     = 1'b1;
        res_data = res_q;
      end
      StErrDone: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  // Datapath: latch request, capture operands, track occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OpPushi;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= ErrOk;
      depth_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= req_op;
        imm_q <= req_imm;
        err_q <= err_code;
      end
      if (state_q == StCapA) begin
        a_q   <= stk_dout;
        res_q <= stk_dout;
      end
      if (state_q == StCapB) b_q <= stk_dout;
      if (state_q == StWr) res_q <= result;
      if (stk_push)      depth_q <= depth_q + 1'b1;
      else if (stk_pop)  depth_q <= depth_q - 1'b1;
    end
  end

endmodule
